arch_map_table_nway: RTL and testbench
======================================

// Module: arch_map_table_nway
// PURPOSE
//  Retirement-side architectural map table for the R10K core, generalised to N-wide retire.
//  - Holds the committed arch-to-phys mapping. Updates from ROB retire slots, indexed by arch register.
//  - Returns each superseded (old) phys tag to the free list.
//  - Checks that every retire's old tag matches the committed mapping.
//  - On a pipeline flush, streams the committed map back to the rename map table over several cycles.
// PARAMETERS
//  NUM_ARCH   32  number of architectural registers; must be a multiple of COPY_W
//  PHYS_BITS  6   phys tag width
//  RETIRE_W   2   retire slots per cycle; slot 0 is oldest
//  COPY_W     4   map entries streamed per recovery beat
//  ZERO_HARD  1   1: arch reg 0 is never remapped
// PORTS
//  clk            in   1                   clock, rising edge
//  reset          in   1                   asynchronous, active-low reset
//  retire_valid   in   RETIRE_W            retire slot valid
//  retire_arch    in   RETIRE_W*5          destination arch register per slot
//  retire_tag     in   RETIRE_W*PHYS_BITS  new phys tag per slot
//  retire_told    in   RETIRE_W*PHYS_BITS  old phys tag per slot (ROB copy)
//  retire_ready   out  1                   retires are accepted this cycle
//  flush          in   1                   ROB flush pulse; starts recovery
//  at_map         out  NUM_ARCH*PHYS_BITS  committed map, registered
//  free_valid     out  RETIRE_W            released tag valid per slot
//  free_tag       out  RETIRE_W*PHYS_BITS  released phys tag per slot
//  copy_valid     out  1                   recovery beat valid
//  copy_base      out  5                   arch index of lane 0 in the current beat
//  copy_tags      out  COPY_W*PHYS_BITS    tags for arch copy_base..copy_base+COPY_W-1
//  copy_done      out  1                   one-cycle pulse on the last recovery beat
//  map_err        out  1                   sticky flag: an old-tag mismatch was seen
// BEHAVIOUR
//  Reset (async assert, sync release) puts every output in a defined state:
//   - at_map[i]=i.
//   - free_valid=0, copy_valid=0, copy_done=0, map_err=0.
//   - FSM in IDLE, so retire_ready=1.
//  FSM has two states: IDLE and COPY.
//   - retire_ready=1 in IDLE and 0 in COPY.
//   - Retires presented while retire_ready=0 are ignored; the ROB must hold them.
//  Retire, when retire_ready=1: slots are processed in order 0..RETIRE_W-1 within the cycle.
//   - Each valid slot j compares retire_told[j] against the map value already updated by slots <j.
//   - On mismatch, map_err is set (sticky until reset); the update still proceeds.
//   - The map entry retire_arch[j] is set to retire_tag[j]. Two slots to the same arch: the later slot wins.
//   - ZERO_HARD=1 and retire_arch[j]=0: the map is unchanged, no compare, and retire_tag[j] is freed.
//  Free list: free_valid/free_tag are registered with 1-cycle latency.
//   - free_tag[j] = retire_told[j], or retire_tag[j] for the zero-register case.
//   - free_valid is cleared in any cycle with no accepted retire.
//  at_map is updated at the clock edge that accepts the retire (visible the next cycle).
//  Flush handling:
//   - flush in IDLE at cycle t: retires in cycle t are still applied, because they are older than the flush.
//   - FSM enters COPY at t+1.
//  COPY streaming:
//   - Beat k (k=0..NUM_ARCH/COPY_W-1) drives copy_valid=1, copy_base=k*COPY_W, and the post-retire at_map entries.
//   - One beat per cycle; there is no backpressure.
//   - copy_done is asserted with the last beat; IDLE follows the next cycle.
//  flush in COPY restarts the stream at beat 0 the next cycle (the map is unchanged, since retires are blocked).
//  Outside COPY: copy_valid=0 and copy_done=0; copy_base and copy_tags are don't-care.
//  Reset asserted mid-COPY: immediate return to IDLE with the reset map; no copy_done is produced.
// TESTING
//  1. Reset release -> at_map[i]=i, retire_ready=1, map_err=0, free_valid=0.
//  2. Slot0 {arch3,tag40,told3} and slot1 {arch5,tag41,told5}:
//     - next cycle map[3]=40, map[5]=41;
//     - free_valid=2'b11, free_tag={5,3}.
//  3. Same cycle, slot0 {arch7,tag50,told7} and slot1 {arch7,tag51,told50}:
//     - map[7]=51, frees {50,7}, map_err stays 0;
//     - repeat with slot1 told=7 -> map_err=1 and sticky.
//  4. Retire {arch0,tag33} with ZERO_HARD=1 -> map[0]=0 and free_tag=33.
//  5. Retire {arch2,tag44} together with flush at cycle t, defaults (8 beats):
//     - copy beats at t+1..t+8, copy_base 0,4,..,28;
//     - beat 0 lane 2 = 44; copy_done at t+8; retire_ready=0 for t+1..t+8.
//  6. flush again at beat 5 -> beat 0 at the next cycle, total beats 6+8.
//     Reset asserted mid-COPY -> copy_valid=0 and retire_ready=1 immediately.

Source files
------------

// File: rtl/arch_map_table_nway_if.sv
// Retire / free-list / recovery bundle for the architectural map table.
// master drives retires and flush; slave is the map table.
interface arch_map_table_nway_if #(
  parameter int NUM_ARCH  = 32,
  parameter int PHYS_BITS = 6,
  parameter int RETIRE_W  = 2,
  parameter int COPY_W    = 4
);
  logic [RETIRE_W-1:0]           retire_valid;
  logic [RETIRE_W*5-1:0]         retire_arch;
  logic [RETIRE_W*PHYS_BITS-1:0] retire_tag;
  logic [RETIRE_W*PHYS_BITS-1:0] retire_told;
  logic                          retire_ready;
  logic                          flush;
  logic [NUM_ARCH*PHYS_BITS-1:0] at_map;
  logic [RETIRE_W-1:0]           free_valid;
  logic [RETIRE_W*PHYS_BITS-1:0] free_tag;
  logic                          copy_valid;
  logic [4:0]                    copy_base;
  logic [COPY_W*PHYS_BITS-1:0]   copy_tags;
  logic                          copy_done;
  logic                          map_err;

  modport master (
    output retire_valid, retire_arch, retire_tag, retire_told, flush,
    input  retire_ready, at_map, free_valid, free_tag,
    input  copy_valid, copy_base, copy_tags, copy_done, map_err
  );

  modport slave (
    input  retire_valid, retire_arch, retire_tag, retire_told, flush,
    output retire_ready, at_map, free_valid, free_tag,
    output copy_valid, copy_base, copy_tags, copy_done, map_err
  );
endinterface

// File: rtl/arch_map_table_nway.sv
// Committed arch->phys map, N-wide retire, old-tag check,
// and multi-beat map recovery stream on flush.
module arch_map_table_nway #(
  parameter int NUM_ARCH  = 32,
  parameter int PHYS_BITS = 6,
  parameter int RETIRE_W  = 2,
  parameter int COPY_W    = 4,
  parameter int ZERO_HARD = 1
) (
  input logic clk,
  input logic reset,
  arch_map_table_nway_if.slave bus
);
  localparam int PB    = PHYS_BITS;
  localparam int BEATS = NUM_ARCH / COPY_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(NUM_ARCH);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic {IDLE, COPY} state_t;

  state_t                     state_q;
  logic [BW-1:0]              beat_q;
  logic [PB-1:0]              map_q [NUM_ARCH];
  logic [PB-1:0]              map_d [NUM_ARCH];
  logic                       err_q, err_d;
  logic [RETIRE_W-1:0]        fv_q, fv_d;
  logic [RETIRE_W*PB-1:0]     ft_q, ft_d;
  logic                       accept;
  logic [4:0]                 ra;
  logic [PB-1:0]              rt, ro;

  assign accept = (state_q == IDLE);

  // Apply retire slots oldest-first so later slots see earlier updates
  always_comb begin
    map_d = map_q;
    err_d = err_q;
    fv_d  = '0;
    ft_d  = ft_q;
    ra    = '0;
    rt    = '0;
    ro    = '0;
    for (int j = 0; j < RETIRE_W; j++) begin
      ra = bus.retire_arch[j*5 +: 5];
      rt = bus.retire_tag[j*PB +: PB];
      ro = bus.retire_told[j*PB +: PB];
      if (accept && bus.retire_valid[j]) begin
        fv_d[j] = 1'b1;
        if (ZERO_HARD != 0 && ra == 5'd0) begin
          ft_d[j*PB +: PB] = rt;
        end else begin
          ft_d[j*PB +: PB] = ro;
          if (map_d[AW'(ra)] != ro) err_d = 1'b1;
          map_d[AW'(ra)] = rt;
        end
      end
    end
  end

  // Committed map, sticky error and registered free-list outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ARCH; i++) map_q[i] <= PB'(i);
      err_q <= 1'b0;
      fv_q  <= '0;
      ft_q  <= '0;
    end else begin
      map_q <= map_d;
      err_q <= err_d;
      fv_q  <= fv_d;
      ft_q  <= ft_d;
    end
  end

  // Recovery FSM: a flush always (re)starts the stream at beat 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          beat_q <= '0;
          if (bus.flush) state_q <= COPY;
        end
        COPY: begin
          if (bus.flush) begin
            beat_q <= '0;
          end else if (beat_q == LAST) begin
            state_q <= IDLE;
            beat_q  <= '0;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          beat_q  <= '0;
        end
      endcase
    end
  end

  // Flatten the map and select the current recovery beat
  always_comb begin
    bus.at_map    = '0;
    bus.copy_tags = '0;
    for (int i = 0; i < NUM_ARCH; i++)
      bus.at_map[i*PB +: PB] = map_q[i];
    for (int l = 0; l < COPY_W; l++)
      bus.copy_tags[l*PB +: PB] =
        map_q[AW'(int'(beat_q) * COPY_W + l)];
  end

  assign bus.copy_base    = 5'(int'(beat_q) * COPY_W);
  assign bus.copy_valid   = (state_q == COPY);
  assign bus.copy_done    = (state_q == COPY) && (beat_q == LAST);
  assign bus.retire_ready = accept;
  assign bus.free_valid   = fv_q;
  assign bus.free_tag     = ft_q;
  assign bus.map_err      = err_q;
endmodule

// File: tb/tb_arch_map_table_nway.sv
// Directed bench for arch_map_table_nway.
// Expected values are hand-derived per step.
module tb_arch_map_table_nway;
  logic clk;
  logic reset;
  int   vec;
  int   miss;
  int   cnt;
  logic [5:0]   m [32];
  logic [191:0] exp_map;
  logic [23:0]  exp_tags;

  arch_map_table_nway_if #(
    .NUM_ARCH(32), .PHYS_BITS(6), .RETIRE_W(2), .COPY_W(4)
  ) bus ();

  arch_map_table_nway #(
    .NUM_ARCH(32), .PHYS_BITS(6), .RETIRE_W(2),
    .COPY_W(4), .ZERO_HARD(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] mp(input int i);
    return bus.at_map[i*6 +: 6];
  endfunction

  task automatic chk(input string tag,
                     input logic [191:0] obs,
                     input logic [191:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ret(input logic [1:0] v,
                     input logic [4:0] a0, input logic [5:0] t0,
                     input logic [5:0] o0,
                     input logic [4:0] a1, input logic [5:0] t1,
                     input logic [5:0] o1);
    bus.retire_valid = v;
    bus.retire_arch  = {a1, a0};
    bus.retire_tag   = {t1, t0};
    bus.retire_told  = {o1, o0};
  endtask

  task automatic idle_in();
    ret(2'b00, 5'd0, 6'd0, 6'd0, 5'd0, 6'd0, 6'd0);
  endtask

  task automatic beat_exp(input int k);
    for (int l = 0; l < 4; l++) exp_tags[l*6 +: 6] = m[4*k + l];
  endtask

  initial begin
    vec   = 0;
    miss  = 0;
    reset = 1'b0;
    bus.flush = 1'b0;
    idle_in();
    for (int i = 0; i < 32; i++) m[i] = 6'(i);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // 1. reset state
    for (int i = 0; i < 32; i++) exp_map[i*6 +: 6] = 6'(i);
    chk("rst_map", bus.at_map, exp_map);
    chk("rst_ready", 192'(bus.retire_ready), 192'(1));
    chk("rst_err", 192'(bus.map_err), 192'(0));
    chk("rst_fv", 192'(bus.free_valid), 192'(0));
    chk("rst_cv", 192'(bus.copy_valid), 192'(0));
    chk("rst_cd", 192'(bus.copy_done), 192'(0));

    // 2. two independent retires
    ret(2'b11, 5'd3, 6'd40, 6'd3, 5'd5, 6'd41, 6'd5);
    tick();
    idle_in();
    m[3] = 6'd40;
    m[5] = 6'd41;
    chk("t2_map3", 192'(mp(3)), 192'(40));
    chk("t2_map5", 192'(mp(5)), 192'(41));
    chk("t2_fv", 192'(bus.free_valid), 192'(2'b11));
    chk("t2_ft", 192'(bus.free_tag), 192'({6'd5, 6'd3}));
    chk("t2_err", 192'(bus.map_err), 192'(0));
    tick();
    chk("t2_fv_clr", 192'(bus.free_valid), 192'(0));

    // 3. same arch in both slots, chained old tag
    ret(2'b11, 5'd7, 6'd50, 6'd7, 5'd7, 6'd51, 6'd50);
    tick();
    idle_in();
    chk("t3_map7", 192'(mp(7)), 192'(51));
    chk("t3_ft", 192'(bus.free_tag), 192'({6'd50, 6'd7}));
    chk("t3_err0", 192'(bus.map_err), 192'(0));
    // slot1 carries the committed tag instead of slot0's new one
    ret(2'b11, 5'd7, 6'd52, 6'd51, 5'd7, 6'd53, 6'd7);
    tick();
    idle_in();
    m[7] = 6'd53;
    chk("t3_map7b", 192'(mp(7)), 192'(53));
    chk("t3_err1", 192'(bus.map_err), 192'(1));
    tick();
    chk("t3_sticky", 192'(bus.map_err), 192'(1));

    // 4. hardwired zero register
    ret(2'b01, 5'd0, 6'd33, 6'd9, 5'd0, 6'd0, 6'd0);
    tick();
    idle_in();
    chk("t4_map0", 192'(mp(0)), 192'(0));
    chk("t4_fv", 192'(bus.free_valid), 192'(2'b01));
    chk("t4_ft0", 192'(bus.free_tag[5:0]), 192'(33));

    // 5. retire together with flush, full 8-beat stream
    ret(2'b01, 5'd2, 6'd44, 6'd2, 5'd0, 6'd0, 6'd0);
    bus.flush = 1'b1;
    chk("t5_ready_t", 192'(bus.retire_ready), 192'(1));
    tick();
    bus.flush = 1'b0;
    idle_in();
    m[2] = 6'd44;
    for (int k = 0; k < 8; k++) begin
      beat_exp(k);
      chk($sformatf("t5_cv%0d", k), 192'(bus.copy_valid), 192'(1));
      chk($sformatf("t5_base%0d", k), 192'(bus.copy_base), 192'(4*k));
      chk($sformatf("t5_tags%0d", k), 192'(bus.copy_tags), 192'(exp_tags));
      chk($sformatf("t5_rdy%0d", k), 192'(bus.retire_ready), 192'(0));
      chk($sformatf("t5_done%0d", k), 192'(bus.copy_done),
          192'(k == 7));
      if (k == 2) ret(2'b01, 5'd9, 6'd60, 6'd9, 5'd0, 6'd0, 6'd0);
      tick();
      if (k == 2) begin
        idle_in();
        chk("t5_blk_map9", 192'(mp(9)), 192'(9));
        chk("t5_blk_fv", 192'(bus.free_valid), 192'(0));
      end
    end
    chk("t5_end_cv", 192'(bus.copy_valid), 192'(0));
    chk("t5_end_cd", 192'(bus.copy_done), 192'(0));
    chk("t5_end_rdy", 192'(bus.retire_ready), 192'(1));
    chk("t5_map2", 192'(mp(2)), 192'(44));

    // 6. flush at beat 5 restarts the stream
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.copy_valid) cnt++;
      chk($sformatf("t6_base%0d", k), 192'(bus.copy_base), 192'(4*k));
      if (k == 5) begin
        chk("t6_nodone5", 192'(bus.copy_done), 192'(0));
        bus.flush = 1'b1;
      end
      tick();
    end
    bus.flush = 1'b0;
    chk("t6_restart_cv", 192'(bus.copy_valid), 192'(1));
    chk("t6_restart_base", 192'(bus.copy_base), 192'(0));
    for (int c = 0; c < 40; c++) begin
      if (!bus.copy_valid) break;
      cnt++;
      if (bus.copy_done) begin
        tick();
        break;
      end
      tick();
    end
    chk("t6_beats", 192'(cnt), 192'(14));
    chk("t6_idle", 192'(bus.copy_valid), 192'(0));

    // reset in the middle of a stream
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();
    tick();
    chk("t7_cv_pre", 192'(bus.copy_valid), 192'(1));
    #2 reset = 1'b0;
    #1;
    chk("t7_cv", 192'(bus.copy_valid), 192'(0));
    chk("t7_cd", 192'(bus.copy_done), 192'(0));
    chk("t7_rdy", 192'(bus.retire_ready), 192'(1));
    chk("t7_map", bus.at_map, exp_map);
    chk("t7_err", 192'(bus.map_err), 192'(0));
    tick();
    reset = 1'b1;
    tick();
    chk("t7_idle", 192'(bus.copy_valid), 192'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
